// File: rtl/fibo_zeck_decode_if.sv
// fibo_zeck_decode_if: request/result bundle between a client and the Zeckendorf decoder
interface fibo_zeck_decode_if;
    logic [15:0] value_in;
    logic        begin_decode;
    logic        busy;
    logic        done;
    logic [4:0]  fib_index;
    logic        is_fib;
    logic [22:0] zeck_out;
    modport master (output value_in, begin_decode, input busy, done, fib_index, is_fib, zeck_out);
    modport slave  (input value_in, begin_decode, output busy, done, fib_index, is_fib, zeck_out);
endinterface

// File: rtl/fibo_zeck_decode.sv
// fibo_zeck_decode: iterative mapping of a 16-bit value onto Fibonacci index, membership and Zeckendorf form
module fibo_zeck_decode (
    input logic                clk,
    input logic                reset_n,
    fibo_zeck_decode_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ASCEND, DESCEND} state_t;
    state_t      state;
    logic [16:0] r0, r1, sum;
    logic [15:0] rem;
    logic [4:0]  idx;
    logic        take;
    logic [22:0] zeck_next;
    // r1 = F(idx), r0 = F(idx-1); zeck_next is zeck_out with the current descend term folded in
    always_comb begin
        sum       = r0 + r1;
        take      = r1 <= {1'b0, rem};
        zeck_next = bus.zeck_out | (take ? (23'd1 << (idx - 5'd2)) : 23'd0);
    end
    // climb to the largest F(n) <= value, then greedily subtract terms on the way back down
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            r0            <= '0;
            r1            <= '0;
            rem           <= '0;
            idx           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.fib_index <= '0;
            bus.is_fib    <= 1'b0;
            bus.zeck_out  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.begin_decode) begin
                    rem          <= bus.value_in;
                    r0           <= 17'd1;
                    r1           <= 17'd1;
                    idx          <= 5'd2;
                    bus.zeck_out <= '0;
                    bus.done     <= 1'b0;
                    bus.busy     <= 1'b1;
                    state        <= ASCEND;
                end
                ASCEND: if (sum <= {1'b0, rem}) begin
                    r1  <= sum;
                    r0  <= r1;
                    idx <= idx + 5'd1;
                end else begin
                    bus.fib_index <= (rem == 16'd0) ? 5'd0 : idx;
                    state         <= DESCEND;
                end
                DESCEND: begin
                    if (take) rem <= rem - r1[15:0];
                    bus.zeck_out <= zeck_next;
                    r1           <= r0;
                    r0           <= r1 - r0;
                    idx          <= idx - 5'd1;
                    if (idx == 5'd2) begin
                        bus.is_fib <= (zeck_next == 23'd0) || ($countones(zeck_next) == 1);
                        bus.done   <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
